// File: rtl/pipe_ctrl_regs_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_regs_if
// Bundle of every non-clock/reset signal of the pipeline control-register
// bank for the 5-stage MIPS core.
//   modport slave  : the register bank (pipe_ctrl_regs)
//   modport master : the surrounding datapath / hazard unit that drives the
//                    fetch/decode values and the stall/flush commands
// Fetch side   : PCNextF, InstrF, PCPlus4F -> PCF, InstrD, PCPlus4D
// Decode side  : rsD, rtD, rdD, RegWriteD, MemWriteD, ALUSrcD, MemtoRegD,
//                RegDstD, ALUControlD
// Hazard side  : StallF, StallD, FlushD, FlushE in; rsE, rtE, WriteRegE/M/W,
//                RegWriteE/M/W, MemtoRegE/M/W out
// Counters     : StallCount, FlushCount (zero unless PIPE_PERF_CNT_EN)
// ---------------------------------------------------------------------------
interface pipe_ctrl_regs_if;
  logic [31:0] PCNextF;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [4:0]  rdD;
  logic        RegWriteD;
  logic        MemWriteD;
  logic        ALUSrcD;
  logic [1:0]  MemtoRegD;
  logic [1:0]  RegDstD;
  logic [2:0]  ALUControlD;
  logic [4:0]  rsE;
  logic [4:0]  rtE;
  logic [4:0]  WriteRegE;
  logic [4:0]  WriteRegM;
  logic [4:0]  WriteRegW;
  logic        RegWriteE;
  logic        RegWriteM;
  logic        RegWriteW;
  logic [1:0]  MemtoRegE;
  logic [1:0]  MemtoRegM;
  logic [1:0]  MemtoRegW;
  logic        MemWriteE;
  logic        MemWriteM;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport slave (
    input  PCNextF, StallF, StallD, FlushD, FlushE, InstrF, PCPlus4F,
           rsD, rtD, rdD, RegWriteD, MemWriteD, ALUSrcD, MemtoRegD,
           RegDstD, ALUControlD,
    output PCF, InstrD, PCPlus4D, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW,
           MemWriteE, MemWriteM, ALUSrcE, ALUControlE, StallCount, FlushCount
  );

  modport master (
    output PCNextF, StallF, StallD, FlushD, FlushE, InstrF, PCPlus4F,
           rsD, rtD, rdD, RegWriteD, MemWriteD, ALUSrcD, MemtoRegD,
           RegDstD, ALUControlD,
    input  PCF, InstrD, PCPlus4D, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW,
           MemWriteE, MemWriteM, ALUSrcE, ALUControlE, StallCount, FlushCount
  );
endinterface

// File: rtl/pipe_ctrl_regs.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_regs
// Pipeline-register bank of the 5-stage MIPS core: PC register, IF/ID,
// ID/EX, EX/MEM and MEM/WB control/index registers. Operand data is
// pipelined elsewhere; only control bits and register indices live here.
// Ports:
//   clk   : rising-edge clock for every register
//   reset : asynchronous active-low reset (assert any time, release sync)
//   bus   : pipe_ctrl_regs_if.slave, all fetch/decode/hazard signals
// Parameters:
//   RESET_PC : PC value loaded on reset
//   RA_REG   : destination index selected by RegDst=2'b10 (jal)
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating 32-bit stall
// and bubble counters; without it StallCount/FlushCount are tied to zero.
// ---------------------------------------------------------------------------
module pipe_ctrl_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  RA_REG   = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  pipe_ctrl_regs_if.slave bus
);

  // PC and IF/ID
  logic [31:0] r_pc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pcplus4_d;

  // ID/EX
  logic [4:0]  r_rs_e;
  logic [4:0]  r_rt_e;
  logic [4:0]  r_rd_e;
  logic [1:0]  r_regdst_e;
  logic        r_regwrite_e;
  logic        r_memwrite_e;
  logic [1:0]  r_memtoreg_e;
  logic        r_alusrc_e;
  logic [2:0]  r_aluctl_e;
  logic [4:0]  w_writereg_e;

  // EX/MEM and MEM/WB
  logic [4:0]  r_writereg_m;
  logic        r_regwrite_m;
  logic        r_memwrite_m;
  logic [1:0]  r_memtoreg_m;
  logic [4:0]  r_writereg_w;
  logic        r_regwrite_w;
  logic [1:0]  r_memtoreg_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (!bus.StallF) begin
      r_pc <= bus.PCNextF;
    end
  end

  // Stall is tested before flush so a branch waiting on a hazard keeps its
  // own instruction in decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_d   <= '0;
      r_pcplus4_d <= '0;
    end else if (bus.StallD) begin
      r_instr_d   <= r_instr_d;
      r_pcplus4_d <= r_pcplus4_d;
    end else if (bus.FlushD) begin
      r_instr_d   <= '0;
      r_pcplus4_d <= '0;
    end else begin
      r_instr_d   <= bus.InstrF;
      r_pcplus4_d <= bus.PCPlus4F;
    end
  end

  // ID/EX never holds; a flush turns it into an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs_e       <= '0;
      r_rt_e       <= '0;
      r_rd_e       <= '0;
      r_regdst_e   <= '0;
      r_regwrite_e <= 1'b0;
      r_memwrite_e <= 1'b0;
      r_memtoreg_e <= '0;
      r_alusrc_e   <= 1'b0;
      r_aluctl_e   <= '0;
    end else if (bus.FlushE) begin
      r_rs_e       <= '0;
      r_rt_e       <= '0;
      r_rd_e       <= '0;
      r_regdst_e   <= '0;
      r_regwrite_e <= 1'b0;
      r_memwrite_e <= 1'b0;
      r_memtoreg_e <= '0;
      r_alusrc_e   <= 1'b0;
      r_aluctl_e   <= '0;
    end else begin
      r_rs_e       <= bus.rsD;
      r_rt_e       <= bus.rtD;
      r_rd_e       <= bus.rdD;
      r_regdst_e   <= bus.RegDstD;
      r_regwrite_e <= bus.RegWriteD;
      r_memwrite_e <= bus.MemWriteD;
      r_memtoreg_e <= bus.MemtoRegD;
      r_alusrc_e   <= bus.ALUSrcD;
      r_aluctl_e   <= bus.ALUControlD;
    end
  end

  // Destination select from registered ID/EX state; 2'b11 is unused and
  // yields register 0 (never forwarded by the hazard unit).
  always_comb begin
    w_writereg_e = '0;
    case (r_regdst_e)
      2'b00:   w_writereg_e = r_rt_e;
      2'b01:   w_writereg_e = r_rd_e;
      2'b10:   w_writereg_e = RA_REG;
      default: w_writereg_e = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_writereg_m <= '0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_memtoreg_m <= '0;
      r_writereg_w <= '0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= '0;
    end else begin
      r_writereg_m <= w_writereg_e;
      r_regwrite_m <= r_regwrite_e;
      r_memwrite_m <= r_memwrite_e;
      r_memtoreg_m <= r_memtoreg_e;
      r_writereg_w <= r_writereg_m;
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.StallD && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (bus.FlushE && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign bus.StallCount = r_stall_cnt;
  assign bus.FlushCount = r_flush_cnt;
`else
  assign bus.StallCount = '0;
  assign bus.FlushCount = '0;
`endif

  assign bus.PCF         = r_pc;
  assign bus.InstrD      = r_instr_d;
  assign bus.PCPlus4D    = r_pcplus4_d;
  assign bus.rsE         = r_rs_e;
  assign bus.rtE         = r_rt_e;
  assign bus.WriteRegE   = w_writereg_e;
  assign bus.RegWriteE   = r_regwrite_e;
  assign bus.MemWriteE   = r_memwrite_e;
  assign bus.MemtoRegE   = r_memtoreg_e;
  assign bus.ALUSrcE     = r_alusrc_e;
  assign bus.ALUControlE = r_aluctl_e;
  assign bus.WriteRegM   = r_writereg_m;
  assign bus.RegWriteM   = r_regwrite_m;
  assign bus.MemWriteM   = r_memwrite_m;
  assign bus.MemtoRegM   = r_memtoreg_m;
  assign bus.WriteRegW   = r_writereg_w;
  assign bus.RegWriteW   = r_regwrite_w;
  assign bus.MemtoRegW   = r_memtoreg_w;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_regs
// Self-checking bench for pipe_ctrl_regs: reset state, a table of directed
// vectors (normal flow, load-use stall, stall-beats-flush, jal, bubbles),
// an asynchronous mid-cycle reset, then randomized cycles compared against a
// stage-queue reference model. Works with or without PIPE_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_regs;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [1:0] regdst;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       alusrc;
    logic [2:0] aluctl;
  } dec_t;

  typedef struct packed {
    logic [31:0] pcnext;
    logic        stallf;
    logic        stalld;
    logic        flushd;
    logic        flushe;
    logic [31:0] instr;
    logic [31:0] pcp4;
    dec_t        dec;
    logic [31:0] e_pcf;
    logic [31:0] e_instr_d;
    logic [31:0] e_pcp4_d;
    logic [4:0]  e_wr_e;
    logic        e_rw_e;
    logic [4:0]  e_wr_m;
    logic        e_rw_m;
    logic [4:0]  e_wr_w;
    logic [1:0]  e_mtr_w;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  pipe_ctrl_regs_if bus ();

  pipe_ctrl_regs #(.RESET_PC(RST_PC), .RA_REG(5'd31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcp4, m_scnt, m_fcnt;
  dec_t        m_pipe [3];   // [0]=E, [1]=M, [2]=W

  function automatic dec_t mkdec(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [1:0] regdst,
                                 input logic rw, input logic mw,
                                 input logic [1:0] mtr, input logic alusrc,
                                 input logic [2:0] aluctl);
    dec_t d;
    d.rs = rs; d.rt = rt; d.rd = rd; d.regdst = regdst; d.regwrite = rw;
    d.memwrite = mw; d.memtoreg = mtr; d.alusrc = alusrc; d.aluctl = aluctl;
    return d;
  endfunction

  // Destination register an instruction in a given stage will write.
  function automatic logic [4:0] dest(input dec_t d);
    case (d.regdst)
      2'b00:   return d.rt;
      2'b01:   return d.rd;
      2'b10:   return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef PIPE_PERF_CNT_EN
    return n;
`else
    return (n == 32'd0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_dec(input dec_t d);
    bus.rsD = d.rs; bus.rtD = d.rt; bus.rdD = d.rd; bus.RegDstD = d.regdst;
    bus.RegWriteD = d.regwrite; bus.MemWriteD = d.memwrite;
    bus.MemtoRegD = d.memtoreg; bus.ALUSrcD = d.alusrc;
    bus.ALUControlD = d.aluctl;
  endtask

  task automatic drive_ctl(input logic [31:0] pcnext, input logic sf, input logic sd,
                           input logic fd, input logic fe, input logic [31:0] instr,
                           input logic [31:0] pcp4);
    bus.PCNextF = pcnext; bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd;
    bus.FlushE = fe; bus.InstrF = instr; bus.PCPlus4F = pcp4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every output against the reference model.
  task automatic chk_model();
    chk("PCF", bus.PCF, m_pc);
    chk("InstrD", bus.InstrD, m_instr);
    chk("PCPlus4D", bus.PCPlus4D, m_pcp4);
    chk("rsE", {27'd0, bus.rsE}, {27'd0, m_pipe[0].rs});
    chk("rtE", {27'd0, bus.rtE}, {27'd0, m_pipe[0].rt});
    chk("WriteRegE", {27'd0, bus.WriteRegE}, {27'd0, dest(m_pipe[0])});
    chk("RegWriteE", {31'd0, bus.RegWriteE}, {31'd0, m_pipe[0].regwrite});
    chk("MemWriteE", {31'd0, bus.MemWriteE}, {31'd0, m_pipe[0].memwrite});
    chk("MemtoRegE", {30'd0, bus.MemtoRegE}, {30'd0, m_pipe[0].memtoreg});
    chk("ALUSrcE", {31'd0, bus.ALUSrcE}, {31'd0, m_pipe[0].alusrc});
    chk("ALUControlE", {29'd0, bus.ALUControlE}, {29'd0, m_pipe[0].aluctl});
    chk("WriteRegM", {27'd0, bus.WriteRegM}, {27'd0, dest(m_pipe[1])});
    chk("RegWriteM", {31'd0, bus.RegWriteM}, {31'd0, m_pipe[1].regwrite});
    chk("MemWriteM", {31'd0, bus.MemWriteM}, {31'd0, m_pipe[1].memwrite});
    chk("MemtoRegM", {30'd0, bus.MemtoRegM}, {30'd0, m_pipe[1].memtoreg});
    chk("WriteRegW", {27'd0, bus.WriteRegW}, {27'd0, dest(m_pipe[2])});
    chk("RegWriteW", {31'd0, bus.RegWriteW}, {31'd0, m_pipe[2].regwrite});
    chk("MemtoRegW", {30'd0, bus.MemtoRegW}, {30'd0, m_pipe[2].memtoreg});
    chk("StallCount", bus.StallCount, cnt_exp(m_scnt));
    chk("FlushCount", bus.FlushCount, cnt_exp(m_fcnt));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " PCF"}, bus.PCF, RST_PC);
    chk({tag, " InstrD"}, bus.InstrD, 32'd0);
    chk({tag, " PCPlus4D"}, bus.PCPlus4D, 32'd0);
    chk({tag, " E/M/W idx+ctl"},
        {7'd0, bus.rsE, bus.rtE, bus.WriteRegE, bus.WriteRegM, bus.WriteRegW},
        32'd0);
    chk({tag, " E/M/W bits"},
        {16'd0, bus.RegWriteE, bus.RegWriteM, bus.RegWriteW, bus.MemtoRegE,
         bus.MemtoRegM, bus.MemtoRegW, bus.MemWriteE, bus.MemWriteM,
         bus.ALUSrcE, bus.ALUControlE},
        32'd0);
    chk({tag, " counters"}, bus.StallCount | bus.FlushCount, 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    logic [31:0] exp_s, exp_f;
    tests = 0;
    failed = 0;

    // rows: pcnext, StallF, StallD, FlushD, FlushE, InstrF, PCPlus4F, decode,
    //       expected PCF, InstrD, PCPlus4D, WriteRegE, RegWriteE,
    //       WriteRegM, RegWriteM, WriteRegW, MemtoRegW
    // lw $8
    vecs[0] = '{32'h0040_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C08_0000, 32'h0040_0004,
                mkdec(5'd0, 5'd8, 5'd0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 3'b010),
                32'h0040_0004, 32'h8C08_0000, 32'h0040_0004, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 2'b00};
    // add $9
    vecs[1] = '{32'h0040_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h014A_4820, 32'h0040_0008,
                mkdec(5'd10, 5'd10, 5'd9, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'b010),
                32'h0040_0008, 32'h014A_4820, 32'h0040_0008, 5'd9, 1'b1, 5'd8, 1'b1, 5'd0, 2'b00};
    // load-use stall: hold F and D, bubble into E
    vecs[2] = '{32'h0040_000C, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0040_000C,
                mkdec(5'd9, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 3'b010),
                32'h0040_0008, 32'h014A_4820, 32'h0040_0008, 5'd0, 1'b0, 5'd9, 1'b1, 5'd8, 2'b01};
    // beq into D; jal in decode fields
    vecs[3] = '{32'h0040_000C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1109_FFFC, 32'h0040_000C,
                mkdec(5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000),
                32'h0040_000C, 32'h1109_FFFC, 32'h0040_000C, 5'd31, 1'b1, 5'd0, 1'b0, 5'd9, 2'b00};
    // StallD and FlushD together: stall wins; RegDst=11 gives dest 0
    vecs[4] = '{32'h0040_0010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0040_0010,
                mkdec(5'd0, 5'd6, 5'd7, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000),
                32'h0040_000C, 32'h1109_FFFC, 32'h0040_000C, 5'd0, 1'b1, 5'd31, 1'b1, 5'd0, 2'b00};
    // FlushD alone clears IF/ID; jal reaches W
    vecs[5] = '{32'h0040_0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0040_0010,
                mkdec(5'd0, 5'd3, 5'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000),
                32'h0040_0010, 32'h0000_0000, 32'h0000_0000, 5'd3, 1'b0, 5'd0, 1'b1, 5'd31, 2'b00};
    // FlushE alone: bubble in E while F and D advance
    vecs[6] = '{32'h0040_0014, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555, 32'h0040_0014,
                mkdec(5'd0, 5'd4, 5'd0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 3'b000),
                32'h0040_0014, 32'hAAAA_5555, 32'h0040_0014, 5'd0, 1'b0, 5'd3, 1'b0, 5'd0, 2'b00};

    // ---------------- reset ----------------
    reset = 1'b0;
    drive_ctl(RST_PC + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C08_0000, 32'h0040_0004);
    drive_dec(mkdec(5'd1, 5'd2, 5'd3, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 3'b111));
    tick();
    tick();
    chk_reset_state("reset");
    $display("[TB] reset held: PCF=%h", bus.PCF);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- directed table ----------------
    exp_s = 32'd0;
    exp_f = 32'd0;
    for (int i = 0; i < 7; i++) begin
      drive_ctl(vecs[i].pcnext, vecs[i].stallf, vecs[i].stalld, vecs[i].flushd,
                vecs[i].flushe, vecs[i].instr, vecs[i].pcp4);
      drive_dec(vecs[i].dec);
      tick();
      exp_s += {31'd0, vecs[i].stalld};
      exp_f += {31'd0, vecs[i].flushe};
      chk($sformatf("v%0d PCF", i), bus.PCF, vecs[i].e_pcf);
      chk($sformatf("v%0d InstrD", i), bus.InstrD, vecs[i].e_instr_d);
      chk($sformatf("v%0d PCPlus4D", i), bus.PCPlus4D, vecs[i].e_pcp4_d);
      chk($sformatf("v%0d WriteRegE", i), {27'd0, bus.WriteRegE}, {27'd0, vecs[i].e_wr_e});
      chk($sformatf("v%0d RegWriteE", i), {31'd0, bus.RegWriteE}, {31'd0, vecs[i].e_rw_e});
      chk($sformatf("v%0d WriteRegM", i), {27'd0, bus.WriteRegM}, {27'd0, vecs[i].e_wr_m});
      chk($sformatf("v%0d RegWriteM", i), {31'd0, bus.RegWriteM}, {31'd0, vecs[i].e_rw_m});
      chk($sformatf("v%0d WriteRegW", i), {27'd0, bus.WriteRegW}, {27'd0, vecs[i].e_wr_w});
      chk($sformatf("v%0d MemtoRegW", i), {30'd0, bus.MemtoRegW}, {30'd0, vecs[i].e_mtr_w});
      chk($sformatf("v%0d StallCount", i), bus.StallCount, cnt_exp(exp_s));
      chk($sformatf("v%0d FlushCount", i), bus.FlushCount, cnt_exp(exp_f));
      $display("[TB] vec %0d: PCF=%h InstrD=%h WrE=%0d WrM=%0d WrW=%0d", i,
               bus.PCF, bus.InstrD, bus.WriteRegE, bus.WriteRegM, bus.WriteRegW);
    end

    // ---------------- asynchronous reset mid-pipeline ----------------
    drive_ctl(32'h0040_0018, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C0C_0000, 32'h0040_0018);
    drive_dec(mkdec(5'd0, 5'd12, 5'd0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000));
    tick();
    tick();
    chk("pre-async RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
    chk("pre-async WriteRegM", {27'd0, bus.WriteRegM}, 32'd12);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async");
    $display("[TB] async reset between edges: RegWriteM=%0d PCF=%h", bus.RegWriteM, bus.PCF);
    @(negedge clk);
    reset = 1'b1;
    drive_ctl(RST_PC + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_dec('0);
    tick();
    chk("first fetch PCF", bus.PCF, RST_PC + 32'd4);
    $display("[TB] post-reset fetch: PCF=%h", bus.PCF);

    // ---------------- randomized against reference model ----------------
    m_pc = RST_PC + 32'd4;
    m_instr = 32'd0;
    m_pcp4 = 32'd0;
    m_scnt = 32'd0;
    m_fcnt = 32'd0;
    for (int k = 0; k < 3; k++) m_pipe[k] = '0;

    for (int n = 0; n < 300; n++) begin
      logic sf, sd, fd, fe;
      dec_t d;
      if ($urandom_range(0, 4) == 0) begin
        sf = 1'b1; sd = 1'b1; fe = 1'b1;
      end else begin
        sf = ($urandom_range(0, 7) == 0);
        sd = ($urandom_range(0, 7) == 0);
        fe = ($urandom_range(0, 7) == 0);
      end
      fd = ($urandom_range(0, 5) == 0);
      d = dec_t'($urandom);
      drive_ctl($urandom, sf, sd, fd, fe, $urandom, $urandom);
      drive_dec(d);
      tick();
      // reference: each register obeys only its own command
      if (!sf) m_pc = bus.PCNextF;
      if (!sd) begin
        m_instr = fd ? 32'd0 : bus.InstrF;
        m_pcp4  = fd ? 32'd0 : bus.PCPlus4F;
      end
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = fe ? dec_t'(0) : d;
      if (sd && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (fe && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      chk_model();
      $display("[TB] rnd %0d: sf=%0d sd=%0d fd=%0d fe=%0d PCF=%h WrE=%0d WrW=%0d",
               n, sf, sd, fd, fe, bus.PCF, bus.WriteRegE, bus.WriteRegW);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
